// File: rtl/bit_scan_pick.sv
// bit_scan_pick: combinational selection of the next bit to emit from a
// residue word.
//
// Ports:
//   residue      in  [W-1:0]     set bits not yet emitted.
//   msb          in  1           1 = pick the highest set bit, 0 = the lowest.
//   index        out [ORDER-1:0] position of the picked bit (0 when residue == 0).
//   last         out 1           residue holds at most one set bit.
//   empty        out 1           residue is all zeros.
//   next_residue out [W-1:0]     residue with the picked bit cleared.
module bit_scan_pick #(
  parameter int ORDER = 3,
  parameter int W     = 2**ORDER
) (
  input  logic [W-1:0]     residue,
  input  logic             msb,
  output logic [ORDER-1:0] index,
  output logic             last,
  output logic             empty,
  output logic [W-1:0]     next_residue
);

  logic [ORDER:0]   tz;
  logic [ORDER:0]   lz;
  logic [ORDER-1:0] hi_index;
  logic [W-1:0]     pick_onehot;

  cix #(.ORDER(ORDER), .LEADING(1'b0)) u_ctz (
    .data  (residue),
    .count (tz)
  );

  cix #(.ORDER(ORDER), .LEADING(1'b1)) u_clz (
    .data  (residue),
    .count (lz)
  );

  // Both counters saturate at W for a zero word; either top bit flags it.
  assign empty = tz[ORDER] & lz[ORDER];

  // For a nonzero word lz < W, so W-1-lz fits in ORDER bits.
  assign hi_index = (ORDER)'(W-1) - lz[ORDER-1:0];

  always_comb begin
    index = '0;
    if (!empty) begin
      index = msb ? hi_index : tz[ORDER-1:0];
    end
  end

  // Clearing the lowest set bit leaves zero exactly when at most one bit was set.
  assign last = ((residue & (residue - 1'b1)) == '0);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_onehot
      assign pick_onehot[gi] = !empty && (index == (ORDER)'(gi));
    end
  endgenerate

  assign next_residue = residue & ~pick_onehot;

endmodule

// File: rtl/cix.sv
// cix: counts the zero bits that come before the first set bit of a word.
//
// Parameters:
//   ORDER   - log2 of the word width (W = 2**ORDER).
//   LEADING - 0: trailing-zero count (ctz), counted up from bit 0.
//             1: leading-zero count (clz), counted down from bit W-1.
// Ports:
//   data  in  [W-1:0]   word to examine.
//   count out [ORDER:0] number of zeros before the first set bit; W when data == 0.
module cix #(
  parameter int ORDER   = 3,
  parameter bit LEADING = 1'b0
) (
  input  logic [2**ORDER-1:0] data,
  output logic [ORDER:0]      count
);

  localparam int W = 2**ORDER;

  // A leading-zero count is a trailing-zero count of the bit-reversed word,
  // so one priority search serves both modes.
  logic [W-1:0] scan;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_scan
      if (LEADING) begin : g_rev
        assign scan[gi] = data[W-1-gi];
      end else begin : g_fwd
        assign scan[gi] = data[gi];
      end
    end
  endgenerate

  // The search runs from the top down so that the lowest set bit is the
  // last one assigned and therefore wins.
  always_comb begin
    count = (ORDER+1)'(W);
    for (int i = W-1; i >= 0; i--) begin
      if (scan[i]) begin
        count = (ORDER+1)'(i);
      end
    end
  end

endmodule

// File: rtl/bit_scan.sv
// bit_scan: accepts one W-bit word per transaction and streams the index of
// every set bit, one index per output beat, lowest- or highest-first.
//
// Parameters:
//   ORDER - log2 of word width.
//   W     - word width (2**ORDER).
// Ports:
//   reset     in  1           asynchronous active-high reset.
//   clock     in  1           rising-edge clock.
//   in_valid  in  1           input word offered.
//   in_ready  out 1           a word can be accepted this cycle.
//   in_data   in  [W-1:0]     word to scan.
//   in_msb    in  1           scan order for this word: 1 = highest bit first.
//   out_valid out 1           output beat present.
//   out_ready in  1           consumer takes the current beat.
//   out_index out [ORDER-1:0] bit position of the current set bit.
//   out_last  out 1           final beat of the word.
//   out_empty out 1           the accepted word was all zeros (single beat).
module bit_scan #(
  parameter int ORDER = 3,
  parameter int W     = 2**ORDER
) (
  input  logic             reset,
  input  logic             clock,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ORDER-1:0] out_index,
  output logic             out_last,
  output logic             out_empty
);

  localparam logic IDLE = 1'b0;
  localparam logic SCAN = 1'b1;

  logic         state;
  logic         state_next;
  logic [W-1:0] residue;
  logic [W-1:0] residue_next;
  logic         order;
  logic         order_next;

  logic [ORDER-1:0] pick_index;
  logic             pick_last;
  logic             pick_empty;
  logic [W-1:0]     pick_next_residue;
  logic             accept;
  logic             beat;

  bit_scan_pick #(.ORDER(ORDER), .W(W)) u_pick (
    .residue      (residue),
    .msb          (order),
    .index        (pick_index),
    .last         (pick_last),
    .empty        (pick_empty),
    .next_residue (pick_next_residue)
  );

  // A zero residue is only ever seen on the first beat, because the final
  // beat of a nonzero word always returns to IDLE; so pick_empty alone
  // identifies an all-zero input word.
  assign out_valid = (state == SCAN);
  assign out_index = out_valid ? pick_index : '0;
  assign out_last  = out_valid & pick_last;
  assign out_empty = out_valid & pick_empty;

  // Ready on the final beat as well, so words follow each other with no bubble.
  assign in_ready = (state == IDLE) | (out_valid & out_ready & out_last);
  assign accept   = in_valid & in_ready;
  assign beat     = out_valid & out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      residue <= '0;
      order   <= 1'b0;
    end else begin
      state   <= state_next;
      residue <= residue_next;
      order   <= order_next;
    end
  end

  always_comb begin
    state_next   = state;
    residue_next = residue;
    order_next   = order;
    if (accept) begin
      // A new word wins over the retiring one when both happen together.
      state_next   = SCAN;
      residue_next = in_data;
      order_next   = in_msb;
    end else if (beat) begin
      residue_next = pick_next_residue;
      if (out_last) begin
        state_next = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_bit_scan.sv
// tb_bit_scan: directed, table-driven checks of bit_scan plus hand-written
// sequences for back-pressure, back-to-back words and mid-scan reset.
module tb_bit_scan;

  localparam int ORDER = 3;
  localparam int W     = 8;

  logic         reset;
  logic         clock;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_msb;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_index;
  logic         out_last;
  logic         out_empty;

  int tests_run;
  int tests_failed;

  bit_scan #(.ORDER(ORDER), .W(W)) dut (
    .reset     (reset),
    .clock     (clock),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_msb    (in_msb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .out_empty (out_empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  data;
    logic        msb;
    int          n;
    logic [23:0] idx;   // expected index k in idx[3*k +: 3]
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end else begin
      $display("ok   %s: %0d at %0t", name, actual, $time);
    end
  endtask

  task automatic check_beat(input string name, input int idx, input bit last,
                            input bit empty);
    check({name, " valid"}, int'(out_valid), 1);
    check({name, " index"}, int'(out_index), idx);
    check({name, " last"},  int'(out_last), int'(last));
    check({name, " empty"}, int'(out_empty), int'(empty));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{data: 8'h00, msb: 1'b0, n: 1, idx: 24'd0};
    vecs[1] = '{data: 8'hA5, msb: 1'b0, n: 4, idx: {12'd0, 3'd7, 3'd5, 3'd2, 3'd0}};
    vecs[2] = '{data: 8'hA5, msb: 1'b1, n: 4, idx: {12'd0, 3'd0, 3'd2, 3'd5, 3'd7}};
    vecs[3] = '{data: 8'hFF, msb: 1'b1, n: 8,
                idx: {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}};
    vecs[4] = '{data: 8'h01, msb: 1'b1, n: 1, idx: {21'd0, 3'd0}};
    vecs[5] = '{data: 8'h80, msb: 1'b0, n: 1, idx: {21'd0, 3'd7}};
    vecs[6] = '{data: 8'h3C, msb: 1'b0, n: 4, idx: {12'd0, 3'd5, 3'd4, 3'd3, 3'd2}};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_msb    = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_index", int'(out_index), 0);
    check("reset out_last",  int'(out_last), 0);
    check("reset out_empty", int'(out_empty), 0);
    check("reset in_ready",  int'(in_ready), 1);
    reset = 1'b0;
    @(negedge clock);

    // Table: one word at a time, consumer always ready.
    for (int v = 0; v < 7; v++) begin
      in_valid = 1'b1;
      in_data  = vecs[v].data;
      in_msb   = vecs[v].msb;
      check($sformatf("vec%0d idle in_ready", v), int'(in_ready), 1);
      @(negedge clock);
      in_valid = 1'b0;
      for (int k = 0; k < vecs[v].n; k++) begin
        logic [23:0] list;
        list = vecs[v].idx;
        check_beat($sformatf("vec%0d beat%0d", v, k), int'(list[3*k +: 3]),
                   (k == vecs[v].n - 1), (vecs[v].data == 8'h00));
        check($sformatf("vec%0d beat%0d in_ready", v, k), int'(in_ready),
              (k == vecs[v].n - 1) ? 1 : 0);
        @(negedge clock);
      end
      check($sformatf("vec%0d done out_valid", v), int'(out_valid), 0);
    end

    // Back-pressure: 8'h81 with consumer stalled for 3 cycles.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h81;
    in_msb    = 1'b0;
    @(negedge clock);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_beat($sformatf("stall c%0d", c), 0, 1'b0, 1'b0);
      check($sformatf("stall c%0d in_ready", c), int'(in_ready), 0);
      @(negedge clock);
    end
    out_ready = 1'b1;
    check_beat("stall release b0", 0, 1'b0, 1'b0);
    @(negedge clock);
    check_beat("stall release b1", 7, 1'b1, 1'b0);
    @(negedge clock);
    check("stall done out_valid", int'(out_valid), 0);

    // Back-to-back: 8'h01 then 8'h80 with no bubble between.
    in_valid = 1'b1;
    in_data  = 8'h01;
    in_msb   = 1'b0;
    @(negedge clock);
    check_beat("b2b first", 0, 1'b1, 1'b0);
    check("b2b in_ready on last", int'(in_ready), 1);
    in_data = 8'h80;
    @(negedge clock);
    in_valid = 1'b0;
    check_beat("b2b second", 7, 1'b1, 1'b0);
    @(negedge clock);
    check("b2b done out_valid", int'(out_valid), 0);

    // Reset in mid-scan of 8'hFF, then a fresh word must show no leftovers.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_msb   = 1'b0;
    @(negedge clock);
    in_valid = 1'b0;
    check_beat("ff beat0", 0, 1'b0, 1'b0);
    @(negedge clock);
    check_beat("ff beat1", 1, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("async reset out_valid", int'(out_valid), 0);
    check("async reset out_index", int'(out_index), 0);
    check("async reset in_ready",  int'(in_ready), 1);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("post reset out_valid", int'(out_valid), 0);
    in_valid = 1'b1;
    in_data  = 8'h10;
    in_msb   = 1'b0;
    @(negedge clock);
    in_valid = 1'b0;
    check_beat("post reset word", 4, 1'b1, 1'b0);
    @(negedge clock);
    check("post reset done out_valid", int'(out_valid), 0);
    @(negedge clock);
    check("post reset no leftover", int'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
